vga_vsync_timing: RTL and testbench



---
 rtl/vga_vsync_timing.sv | 102 ++++++++++
 tb/tb_vga_vsync_timing.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_vsync_timing.sv
`default_nettype none
// ============================================================================
// Module   : vga_vsync_timing
// Brief    : Vertical timing stage. Line/frame counters plus registered
//            vsync, active-window, pixel-coordinate and strobe decode.
// Revision : 1.0
// ============================================================================
module vga_vsync_timing #(
    parameter int H_TOTAL     = 800,
    parameter int H_ACT_START = 144,
    parameter int H_ACTIVE    = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_ACT_START = 35,
    parameter int V_ACTIVE    = 480
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       v_sync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam logic [9:0] c_h_total     = 10'(H_TOTAL);
    localparam logic [9:0] c_h_last      = 10'(H_TOTAL - 1);
    localparam logic [9:0] c_h_act_start = 10'(H_ACT_START);
    localparam logic [9:0] c_h_act_end   = 10'(H_ACT_START + H_ACTIVE);
    localparam logic [9:0] c_v_last      = 10'(V_TOTAL - 1);
    localparam logic [9:0] c_v_sync      = 10'(V_SYNC);
    localparam logic [9:0] c_v_act_start = 10'(V_ACT_START);
    localparam logic [9:0] c_v_act_end   = 10'(V_ACT_START + V_ACTIVE);

    logic [9:0] r_v_count;
    logic [7:0] r_frame_count;
    logic       r_v_sync;
    logic       r_video_on;
    logic [9:0] r_pixel_x;
    logic [9:0] r_pixel_y;
    logic       r_line_start;
    logic       r_frame_start;

    logic w_h_legal;
    logic w_line_end;
    logic w_frame_end;
    logic w_hact;
    logic w_vact;
    logic w_video_on;

    // Out-of-range horizontal counts are plain blanking: no advance, no window.
    assign w_h_legal   = (h_count < c_h_total);
    assign w_line_end  = (h_count == c_h_last);
    assign w_frame_end = (r_v_count == c_v_last);
    assign w_hact      = w_h_legal && (h_count >= c_h_act_start) && (h_count < c_h_act_end);
    assign w_vact      = (r_v_count >= c_v_act_start) && (r_v_count < c_v_act_end);
    assign w_video_on  = w_hact && w_vact;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_v_count     <= '0;
            r_frame_count <= '0;
            r_v_sync      <= 1'b1;
            r_video_on    <= 1'b0;
            r_pixel_x     <= '0;
            r_pixel_y     <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            if (w_line_end) begin
                if (w_frame_end) begin
                    r_v_count     <= '0;
                    r_frame_count <= r_frame_count + 8'd1;
                end else begin
                    r_v_count <= r_v_count + 10'd1;
                end
            end
            // Decode uses the pre-advance line so vsync stays aligned with hsync.
            r_v_sync      <= !(r_v_count < c_v_sync);
            r_video_on    <= w_video_on;
            r_pixel_x     <= w_video_on ? (h_count - c_h_act_start) : '0;
            r_pixel_y     <= w_video_on ? (r_v_count - c_v_act_start) : '0;
            r_line_start  <= (h_count == '0);
            r_frame_start <= (h_count == '0) && (r_v_count == '0);
        end
    end

    assign v_count     = r_v_count;
    assign frame_count = r_frame_count;
    assign v_sync      = r_v_sync;
    assign video_on    = r_video_on;
    assign pixel_x     = r_pixel_x;
    assign pixel_y     = r_pixel_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_vsync_timing.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_vsync_timing
// Brief    : Directed self-checking bench for vga_vsync_timing.
// Revision : 1.0
// ============================================================================
module tb_vga_vsync_timing;

    logic       clock;
    logic       reset;
    logic [9:0] h_count;

    logic [9:0] v_count;
    logic       v_sync;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_count;

    // Small-frame instance so the 256-frame wrap fits in a short run.
    logic [9:0] s_v_count;
    logic       s_v_sync;
    logic       s_video_on;
    logic [9:0] s_pixel_x;
    logic [9:0] s_pixel_y;
    logic       s_line_start;
    logic       s_frame_start;
    logic [7:0] s_frame_count;

    int n_pass;
    int n_total;

    vga_vsync_timing dut (
        .clock       (clock),
        .reset       (reset),
        .h_count     (h_count),
        .v_count     (v_count),
        .v_sync      (v_sync),
        .video_on    (video_on),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .line_start  (line_start),
        .frame_start (frame_start),
        .frame_count (frame_count)
    );

    vga_vsync_timing #(
        .V_TOTAL     (4),
        .V_SYNC      (1),
        .V_ACT_START (1),
        .V_ACTIVE    (2)
    ) dut_small (
        .clock       (clock),
        .reset       (reset),
        .h_count     (h_count),
        .v_count     (s_v_count),
        .v_sync      (s_v_sync),
        .video_on    (s_video_on),
        .pixel_x     (s_pixel_x),
        .pixel_y     (s_pixel_y),
        .line_start  (s_line_start),
        .frame_start (s_frame_start),
        .frame_count (s_frame_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Present h for one edge, then sample 1 time unit after the edge.
    task automatic step(input int h);
        h_count = 10'(h);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(500);
        reset = 1'b0;
    endtask

    task automatic run_lines(input int n);
        for (int i = 0; i < n; i++) step(799);
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (v_count !== 10'd0) $display("FAIL reset_v_count got %0d want 0", v_count); else n_pass++;
        n_total++; if (v_sync !== 1'b1) $display("FAIL reset_v_sync got %b want 1", v_sync); else n_pass++;
        n_total++; if (video_on !== 1'b0) $display("FAIL reset_video_on got %b want 0", video_on); else n_pass++;
        n_total++; if (pixel_x !== 10'd0 || pixel_y !== 10'd0)
            $display("FAIL reset_pixel got x=%0d y=%0d want 0/0", pixel_x, pixel_y); else n_pass++;
        n_total++; if (line_start !== 1'b0 || frame_start !== 1'b0)
            $display("FAIL reset_strobes got ls=%b fs=%b want 0/0", line_start, frame_start); else n_pass++;
        n_total++; if (frame_count !== 8'd0) $display("FAIL reset_frame_count got %0d want 0", frame_count); else n_pass++;
    endtask

    task automatic test_line_advance();
        int pulses;
        pulses = 0;
        do_reset();
        for (int s = 0; s < 2; s++) begin
            for (int h = 0; h < 800; h++) begin
                step(h);
                if (line_start === 1'b1) pulses++;
                n_total++;
                if (v_count !== 10'((h == 799) ? s + 1 : s))
                    $display("FAIL line_v_count s=%0d h=%0d got %0d want %0d", s, h, v_count, (h == 799) ? s + 1 : s);
                else n_pass++;
                n_total++;
                if (line_start !== (h == 0))
                    $display("FAIL line_start s=%0d h=%0d got %b want %b", s, h, line_start, (h == 0));
                else n_pass++;
                n_total++;
                if (v_sync !== 1'b0)
                    $display("FAIL line_v_sync s=%0d h=%0d got %b want 0", s, h, v_sync);
                else n_pass++;
                if (h == 0) begin
                    n_total++;
                    if (frame_start !== (s == 0))
                        $display("FAIL line_frame_start s=%0d got %b want %b", s, frame_start, (s == 0));
                    else n_pass++;
                end
            end
        end
        n_total++; if (pulses != 2) $display("FAIL line_pulse_count got %0d want 2", pulses); else n_pass++;
        step(0);
        n_total++; if (v_sync !== 1'b1) $display("FAIL line2_v_sync got %b want 1", v_sync); else n_pass++;
    endtask

    task automatic test_vsync_wrap();
        do_reset();
        step(799);
        n_total++; if (v_sync !== 1'b0 || v_count !== 10'd1)
            $display("FAIL vs_line0 got vs=%b v=%0d want 0/1", v_sync, v_count); else n_pass++;
        step(799);
        n_total++; if (v_sync !== 1'b0 || v_count !== 10'd2)
            $display("FAIL vs_line1 got vs=%b v=%0d want 0/2", v_sync, v_count); else n_pass++;
        step(799);
        n_total++; if (v_sync !== 1'b1) $display("FAIL vs_line2 got %b want 1", v_sync); else n_pass++;
        run_lines(521);
        n_total++; if (v_count !== 10'd524 || frame_count !== 8'd0)
            $display("FAIL wrap_pre got v=%0d fc=%0d want 524/0", v_count, frame_count); else n_pass++;
        step(799);
        n_total++; if (v_count !== 10'd0 || frame_count !== 8'd1)
            $display("FAIL wrap_post got v=%0d fc=%0d want 0/1", v_count, frame_count); else n_pass++;
        step(0);
        n_total++; if (frame_start !== 1'b1 || line_start !== 1'b1)
            $display("FAIL wrap_frame_start got fs=%b ls=%b want 1/1", frame_start, line_start); else n_pass++;
        step(1);
        n_total++; if (frame_start !== 1'b0) $display("FAIL wrap_fs_clear got %b want 0", frame_start); else n_pass++;
        run_lines(525);
        n_total++; if (frame_count !== 8'd2 || v_count !== 10'd0)
            $display("FAIL wrap_second got fc=%0d v=%0d want 2/0", frame_count, v_count); else n_pass++;
    endtask

    task automatic test_corners();
        do_reset();
        run_lines(35);
        step(144);
        n_total++; if (video_on !== 1'b1 || pixel_x !== 10'd0 || pixel_y !== 10'd0)
            $display("FAIL corner_tl got on=%b x=%0d y=%0d want 1/0/0", video_on, pixel_x, pixel_y); else n_pass++;
        step(784);
        n_total++; if (video_on !== 1'b0 || pixel_x !== 10'd0)
            $display("FAIL corner_h784 got on=%b x=%0d want 0/0", video_on, pixel_x); else n_pass++;
        step(143);
        n_total++; if (video_on !== 1'b0 || pixel_x !== 10'd0)
            $display("FAIL corner_h143 got on=%b x=%0d want 0/0", video_on, pixel_x); else n_pass++;
        step(500);
        n_total++; if (video_on !== 1'b1 || pixel_x !== 10'd356 || pixel_y !== 10'd0)
            $display("FAIL corner_mid got on=%b x=%0d y=%0d want 1/356/0", video_on, pixel_x, pixel_y); else n_pass++;
        run_lines(479);
        step(783);
        n_total++; if (video_on !== 1'b1 || pixel_x !== 10'd639 || pixel_y !== 10'd479)
            $display("FAIL corner_br got on=%b x=%0d y=%0d want 1/639/479", video_on, pixel_x, pixel_y); else n_pass++;
        step(799);
        step(200);
        n_total++; if (video_on !== 1'b0 || pixel_y !== 10'd0)
            $display("FAIL corner_v515 got on=%b y=%0d want 0/0", video_on, pixel_y); else n_pass++;
    endtask

    task automatic test_mid_reset_illegal();
        do_reset();
        run_lines(825);
        step(400);
        n_total++; if (v_count !== 10'd300 || frame_count !== 8'd1)
            $display("FAIL mid_pre got v=%0d fc=%0d want 300/1", v_count, frame_count); else n_pass++;
        reset = 1'b1;
        step(400);
        reset = 1'b0;
        n_total++; if (v_count !== 10'd0 || frame_count !== 8'd0 || video_on !== 1'b0)
            $display("FAIL mid_reset got v=%0d fc=%0d on=%b want 0/0/0", v_count, frame_count, video_on); else n_pass++;
        run_lines(40);
        for (int i = 0; i < 10; i++) begin
            step(1000);
            n_total++;
            if (v_count !== 10'd40 || video_on !== 1'b0 || line_start !== 1'b0 || frame_start !== 1'b0)
                $display("FAIL illegal_h i=%0d got v=%0d on=%b ls=%b fs=%b want 40/0/0/0",
                         i, v_count, video_on, line_start, frame_start);
            else n_pass++;
        end
    endtask

    task automatic test_frame_wrap();
        do_reset();
        run_lines(255 * 4);
        n_total++; if (s_frame_count !== 8'd255 || s_v_count !== 10'd0)
            $display("FAIL fwrap_255 got fc=%0d v=%0d want 255/0", s_frame_count, s_v_count); else n_pass++;
        run_lines(3);
        n_total++; if (s_frame_count !== 8'd255 || s_v_count !== 10'd3)
            $display("FAIL fwrap_pre got fc=%0d v=%0d want 255/3", s_frame_count, s_v_count); else n_pass++;
        step(799);
        n_total++; if (s_frame_count !== 8'd0 || s_v_count !== 10'd0)
            $display("FAIL fwrap_0 got fc=%0d v=%0d want 0/0", s_frame_count, s_v_count); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b0;
        h_count = 10'd0;
        test_reset();
        test_line_advance();
        test_vsync_wrap();
        test_corners();
        test_mid_reset_illegal();
        test_frame_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
